// File: rtl/jtag_master_shifter.sv
`default_nettype none
// ============================================================================
// Module : jtag_master_shifter
// Host-side JTAG initiator: runs TAP reset / IR scan / DR scan from Run-Test/Idle.
// Rev    : 1.0
// ============================================================================
module jtag_master_shifter #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              jtag_tck_o,
    output logic              jtag_tms_o,
    output logic              jtag_tdi_o,
    output logic              jtag_trst_no,
    input  logic              jtag_tdo_i
);
    localparam int IDX_W = (LEN_W > 3) ? LEN_W : 3;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_IDLE  = 3'd1,
        S_PRE   = 3'd2,
        S_SHIFT = 3'd3,
        S_POST  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         op_q, op_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DATA_W-1:0]  sh_q, sh_d;
    logic [DATA_W-1:0]  cap_q, cap_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               trst_n_q, trst_n_d;
    logic [IDX_W-1:0]   idx_inc;
    logic               phase_end;
    logic               period_end;

    // TMS preamble from Run-Test/Idle: reset 1,1,1,1,1,0; IR 1,1,0,0; DR 1,0,0
    function automatic logic pre_tms(input logic [1:0] op, input logic [IDX_W-1:0] idx);
        logic r;
        unique case (op)
            OP_RESET: r = (idx < IDX_W'(5));
            OP_IR:    r = (idx < IDX_W'(2));
            default:  r = (idx == '0);
        endcase
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] pre_last(input logic [1:0] op);
        logic [IDX_W-1:0] r;
        unique case (op)
            OP_RESET: r = IDX_W'(5);
            OP_IR:    r = IDX_W'(3);
            default:  r = IDX_W'(2);
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        idx_d      = idx_q;
        op_d       = op_q;
        len_d      = len_q;
        sh_d       = sh_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        trst_n_d   = trst_n_q;
        idx_inc    = idx_q + 1'b1;
        phase_end  = (div_q == DIV_LAST);
        period_end = 1'b0;

        unique case (state_q)
            S_RST: begin
                state_d  = S_IDLE;
                trst_n_d = 1'b1;
            end
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d  = cmd_op_i;
                    len_d = cmd_len_i;
                    sh_d  = cmd_data_i;
                    cap_d = '0;
                    div_d = '0;
                    idx_d = '0;
                    tck_d = 1'b0;
                    tdi_d = 1'b0;
                    if (cmd_op_i == OP_RSVD) begin
                        state_d    = S_DONE;
                        rsp_data_d = '0;
                    end else begin
                        state_d  = S_PRE;
                        tms_d    = pre_tms(cmd_op_i, '0);
                        trst_n_d = (cmd_op_i != OP_RESET);
                    end
                end
            end
            S_PRE, S_SHIFT, S_POST: begin
                if (!phase_end) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!tck_q) begin
                        tck_d = 1'b1;
                        if (state_q == S_SHIFT) begin
                            cap_d[idx_q[LEN_W-1:0]] = jtag_tdo_i;
                        end
                    end else begin
                        tck_d      = 1'b0;
                        period_end = 1'b1;
                    end
                end

                // Falling TCK: launch next TMS/TDI or move to the next segment
                if (period_end) begin
                    unique case (state_q)
                        S_PRE: begin
                            if (idx_q == pre_last(op_q)) begin
                                idx_d = '0;
                                if (op_q == OP_RESET) begin
                                    state_d    = S_DONE;
                                    trst_n_d   = 1'b1;
                                    rsp_data_d = '0;
                                end else begin
                                    state_d = S_SHIFT;
                                    tms_d   = (len_q == '0);
                                    tdi_d   = sh_q[0];
                                    sh_d    = sh_q >> 1;
                                end
                            end else begin
                                idx_d = idx_inc;
                                tms_d = pre_tms(op_q, idx_inc);
                            end
                        end
                        S_SHIFT: begin
                            if (idx_q == IDX_W'(len_q)) begin
                                state_d = S_POST;
                                idx_d   = '0;
                                tms_d   = 1'b1;
                                tdi_d   = 1'b0;
                            end else begin
                                idx_d = idx_inc;
                                tms_d = (idx_inc == IDX_W'(len_q));
                                tdi_d = sh_q[0];
                                sh_d  = sh_q >> 1;
                            end
                        end
                        default: begin
                            if (idx_q[0]) begin
                                state_d    = S_DONE;
                                rsp_data_d = cap_q;
                            end else begin
                                idx_d = idx_inc;
                                tms_d = 1'b0;
                            end
                        end
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_RST;
            div_q      <= '0;
            idx_q      <= '0;
            op_q       <= '0;
            len_q      <= '0;
            sh_q       <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            trst_n_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            len_q      <= len_d;
            sh_q       <= sh_d;
            cap_q      <= cap_d;
            rsp_data_q <= rsp_data_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            trst_n_q   <= trst_n_d;
        end
    end

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE) && (state_q != S_RST);
    assign rsp_valid_o  = (state_q == S_DONE);
    assign rsp_data_o   = rsp_data_q;
    assign jtag_tck_o   = tck_q;
    assign jtag_tms_o   = tms_q;
    assign jtag_tdi_o   = tdi_q;
    assign jtag_trst_no = trst_n_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_master_shifter.sv
`default_nettype none
// Bench for jtag_master_shifter: scoreboarded commands against a small TAP model.
module tb_jtag_master_shifter;
    localparam int DATA_W  = 32;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 5;
    localparam logic [31:0] IDCODE = 32'h04F5484D;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6, EX2DR = 7;
    localparam int UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready_o;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic              busy_o;
    logic              jtag_tck_o;
    logic              jtag_tms_o;
    logic              jtag_tdi_o;
    logic              jtag_trst_no;
    logic              jtag_tdo;

    jtag_master_shifter #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op),
        .cmd_len_i    (cmd_len),
        .cmd_data_i   (cmd_data),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .busy_o       (busy_o),
        .jtag_tck_o   (jtag_tck_o),
        .jtag_tms_o   (jtag_tms_o),
        .jtag_tdi_o   (jtag_tdi_o),
        .jtag_trst_no (jtag_trst_no),
        .jtag_tdo_i   (jtag_tdo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- TAP model (TDO source 0), loopback (1), tied high (2)
    int         tdo_mode = 0;
    int         tap_st = TLR;
    logic [4:0] ir = 5'd1;
    logic [4:0] ir_sr = 5'd0;
    logic [31:0] dr_sr = 32'd0;
    logic       tap_tdo = 1'b0;
    logic       tms_h[$];
    logic       tdi_h[$];
    logic       trst_h[$];

    assign jtag_tdo = (tdo_mode == 1) ? jtag_tdi_o : (tdo_mode == 2) ? 1'b1 : tap_tdo;

    function automatic int tap_next(input int s, input logic t);
        case (s)
            TLR:   return t ? TLR   : RTI;
            RTI:   return t ? SELDR : RTI;
            SELDR: return t ? SELIR : CAPDR;
            CAPDR: return t ? EX1DR : SHDR;
            SHDR:  return t ? EX1DR : SHDR;
            EX1DR: return t ? UPDR  : PADR;
            PADR:  return t ? EX2DR : PADR;
            EX2DR: return t ? UPDR  : SHDR;
            UPDR:  return t ? SELDR : RTI;
            SELIR: return t ? TLR   : CAPIR;
            CAPIR: return t ? EX1IR : SHIR;
            SHIR:  return t ? EX1IR : SHIR;
            EX1IR: return t ? UPIR  : PAIR;
            PAIR:  return t ? EX2IR : PAIR;
            EX2IR: return t ? UPIR  : SHIR;
            default: return t ? SELDR : RTI;
        endcase
    endfunction

    // TRST acts at its falling edge (TCK is low then); TCK rises step the TAP.
    always @(posedge jtag_tck_o or negedge jtag_trst_no) begin
        if (!jtag_tck_o) begin
            tap_st = TLR;
            ir     = 5'd1;
        end else begin
            tms_h.push_back(jtag_tms_o);
            tdi_h.push_back(jtag_tdi_o);
            trst_h.push_back(jtag_trst_no);
            case (tap_st)
                TLR:   ir = 5'd1;
                CAPDR: dr_sr = (ir == 5'd1) ? IDCODE : 32'd0;
                SHDR:  dr_sr = {jtag_tdi_o, dr_sr[31:1]};
                CAPIR: ir_sr = 5'b00001;
                SHIR:  ir_sr = {jtag_tdi_o, ir_sr[4:1]};
                UPIR:  ir = ir_sr;
                default: ;
            endcase
            tap_st = tap_next(tap_st, jtag_tms_o);
        end
    end

    always @(negedge jtag_tck_o) begin
        if (tap_st == SHDR)      tap_tdo = dr_sr[0];
        else if (tap_st == SHIR) tap_tdo = ir_sr[0];
        else                     tap_tdo = 1'b0;
    end

    // ---------------- scoreboard
    typedef struct {
        logic [31:0] data;
        int          cyc;
        int          start;
        int          n;
        logic [63:0] tms;
        logic [63:0] tdi;
        int          trst_hi;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    logic [63:0] got_tms;
    logic [63:0] got_tdi;
    int          got_trst;
    int          last_acc = 0;

    function automatic exp_t mk(input logic [1:0] op, input int len, input logic [31:0] data,
                                input logic [31:0] rsp);
        exp_t e;
        int k = 0;
        int pre;
        e.tms = '0;
        e.tdi = '0;
        if (op == 2'b00) begin
            for (int i = 0; i < 6; i++) begin e.tms[k] = (i < 5); k++; end
        end else if (op != 2'b11) begin
            pre = (op == 2'b01) ? 4 : 3;
            for (int i = 0; i < pre; i++) begin
                e.tms[k] = (op == 2'b01) ? (i < 2) : (i == 0);
                k++;
            end
            for (int i = 0; i <= len; i++) begin
                e.tms[k] = (i == len);
                e.tdi[k] = data[i];
                k++;
            end
            e.tms[k] = 1'b1; k++;
            e.tms[k] = 1'b0; k++;
        end
        e.n       = k;
        e.data    = rsp;
        e.trst_hi = (op == 2'b01 || op == 2'b10) ? k : 0;
        e.cyc     = 0;
        e.start   = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rsp_valid_o) begin
            if (sb.size() == 0) begin
                check_eq("stray_rsp", 64'd1, 64'd0);
            end else begin
                e_m = sb.pop_front();
                got_tms  = '0;
                got_tdi  = '0;
                got_trst = 0;
                for (int i = e_m.start; i < tms_h.size(); i++) begin
                    if (i - e_m.start < 64) begin
                        got_tms[i - e_m.start] = tms_h[i];
                        got_tdi[i - e_m.start] = tdi_h[i];
                    end
                    if (trst_h[i]) got_trst++;
                end
                check_eq("rsp_data",  rsp_data_o, e_m.data);
                check_eq("rsp_cycle", cyc, e_m.cyc);
                check_eq("tck_count", tms_h.size() - e_m.start, e_m.n);
                check_eq("tms_seq",   got_tms, e_m.tms);
                check_eq("tdi_seq",   got_tdi, e_m.tdi);
                check_eq("trst_high", got_trst, e_m.trst_hi);
                check_eq("tap_rti",   tap_st, RTI);
                check_eq("tms_end",   jtag_tms_o, 1'b0);
            end
        end
    end

    task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                           input logic [31:0] rsp);
        exp_t e;
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len[LEN_W-1:0];
        cmd_data  = data;
        while (!cmd_ready_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready_o) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
            return;
        end
        e       = mk(op, len, data, rsp);
        e.cyc   = cyc + 1 + 2 * CLK_DIV * e.n;
        e.start = tms_h.size();
        sb.push_back(e);
        last_acc = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic done_cmd();
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) check_eq("rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int e1;
        int s0;
        int t;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tck",   jtag_tck_o, 1'b0);
        check_eq("rst_tms",   jtag_tms_o, 1'b1);
        check_eq("rst_tdi",   jtag_tdi_o, 1'b0);
        check_eq("rst_trst",  jtag_trst_no, 1'b0);
        check_eq("rst_ready", cmd_ready_o, 1'b0);
        check_eq("rst_rspv",  rsp_valid_o, 1'b0);
        check_eq("rst_rspd",  rsp_data_o, 32'd0);
        check_eq("rst_busy",  busy_o, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_ready", cmd_ready_o, 1'b1);
        check_eq("idle_trst",  jtag_trst_no, 1'b1);
        check_eq("idle_busy",  busy_o, 1'b0);

        run_cmd(2'b00, 0, 32'd0, 32'd0);
        done_cmd();

        tdo_mode = 1;
        run_cmd(2'b10, 7, 32'hFFFF_FFA5, 32'h0000_00A5);
        done_cmd();
        repeat (4) @(negedge clk);
        check_eq("rsp_hold",   rsp_data_o, 32'hA5);
        check_eq("hold_tck",   jtag_tck_o, 1'b0);
        check_eq("hold_ready", cmd_ready_o, 1'b1);

        tdo_mode = 0;
        run_cmd(2'b01, 4, 32'h1, 32'h1);
        done_cmd();
        run_cmd(2'b10, 31, 32'h0, IDCODE);
        done_cmd();

        tdo_mode = 2;
        run_cmd(2'b10, 31, 32'h1234_5678, 32'hFFFF_FFFF);
        done_cmd();
        run_cmd(2'b10, 0, 32'h0, 32'h1);
        done_cmd();

        // Reserved op with cmd_valid kept high straight into the next command
        run_cmd(2'b11, 0, 32'hDEAD_BEEF, 32'd0);
        e1 = last_acc;
        check_eq("rsvd_done_ready", cmd_ready_o, 1'b0);
        check_eq("rsvd_done_rspv",  rsp_valid_o, 1'b1);
        check_eq("rsvd_tck",        jtag_tck_o, 1'b0);
        run_cmd(2'b00, 0, 32'd0, 32'd0);
        check_eq("b2b_spacing", last_acc - e1, 2);
        done_cmd();

        // Reset in the middle of shift bit 3 of an 8-bit DR scan
        tdo_mode = 1;
        s0 = tms_h.size();
        run_cmd(2'b10, 7, 32'h3C, 32'h3C);
        t = 0;
        while (tms_h.size() - s0 < 7 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("mid_reached", (tms_h.size() - s0 >= 7), 1'b1);
        check_eq("mid_busy", busy_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_tck",   jtag_tck_o, 1'b0);
        check_eq("midrst_tms",   jtag_tms_o, 1'b1);
        check_eq("midrst_trst",  jtag_trst_no, 1'b0);
        check_eq("midrst_busy",  busy_o, 1'b0);
        check_eq("midrst_rspv",  rsp_valid_o, 1'b0);
        check_eq("midrst_ready", cmd_ready_o, 1'b0);
        sb.delete();
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", cmd_ready_o, 1'b1);
        run_cmd(2'b00, 0, 32'd0, 32'd0);
        done_cmd();

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/jtag_master_shifter.md
# jtag_master_shifter

Host-side JTAG driver that generates TCK/TMS/TDI and captures TDO, i.e. the initiator end of the SoC's JTAG TAP port (jtag_tck_i/tms_i/trst_ni/tdi_i/tdo_o). It accepts one command at a time (TAP reset, IR scan, DR scan) over a valid/ready handshake, walks the TAP state machine from Run-Test/Idle and back, and returns the captured TDO bits in a one-cycle response. It is used in on-FPGA self-test and loopback benches against the debug module's TAP.

## Interface
- DATA_W, 32: maximum scan length in bits; rsp/cmd data width.
- CLK_DIV, 2: clk_i cycles per TCK half-period, ≥1.
- LEN_W, $clog2(DATA_W): width of cmd_len_i.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_op_i  in  2  00 TAP_RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 reserved.
- cmd_len_i  in  LEN_W  scan length minus 1 (0 → 1 bit, DATA_W-1 → DATA_W bits).
- cmd_data_i  in  DATA_W  TDI bits, LSB shifted first.
- rsp_valid_o  out  1  one-cycle pulse, command complete; no backpressure.
- rsp_data_o  out  DATA_W  captured TDO, right-aligned, bit i = i-th shifted bit; bits ≥ length are 0.
- busy_o  out  1  command in progress (state ≠ IDLE).
- jtag_tck_o  out  1  TCK.
- jtag_tms_o  out  1  TMS.
- jtag_tdi_o  out  1  TDI.
- jtag_trst_no  out  1  TRST, active-low.
- jtag_tdo_i  in  1  TDO from target.

## Operation
- Handshake: accept when cmd_valid_i && cmd_ready_o; op/len/data latched that cycle; inputs ignored otherwise.
- FSM: IDLE → PRE (TMS preamble) → SHIFT → POST (TMS postamble) → DONE (1 cycle, rsp_valid_o=1) → IDLE. TAP_RESET skips SHIFT/POST.
- Each TCK period = low phase (CLK_DIV cycles) then high phase (CLK_DIV cycles). TMS/TDI updated on the clk_i edge that drives TCK low (start of period); TDO sampled on the clk_i edge that drives TCK high.
- TAP_RESET: TMS = 1,1,1,1,1,0 (6 TCKs) → Run-Test/Idle. jtag_trst_no = 0 for the whole op, 1 otherwise (after reset).
- SHIFT_DR: PRE TMS 1,0,0; SHIFT L bits, TMS=0 except last bit TMS=1 (Exit1); POST TMS 1,0 → RTI. N = L+5 TCKs.
- SHIFT_IR: PRE TMS 1,1,0,0; SHIFT as DR; POST 1,0. N = L+6.
- TDI driven 0 outside SHIFT. TDO sampled only during SHIFT bits; bit i of rsp_data_o = TDO at rising TCK of shift bit i.
- Reserved op 11: accepted, no TCK activity, DONE next cycle with rsp_data_o = 0.
- Between commands TCK held 0, TMS/TDI hold last value (0 after any completed op).

## Timing
- Reset values (and all outputs while rst_i=1): jtag_tck_o 0, jtag_tms_o 1, jtag_tdi_o 0, jtag_trst_no 0, cmd_ready_o 0, rsp_valid_o 0, rsp_data_o 0, busy_o 0. Cycle after rst_i falls: IDLE, cmd_ready_o 1, jtag_trst_no 1.
- rst_i during any state: next cycle all outputs at reset values, partial scan discarded, no rsp_valid_o.
- Accept at cycle T: first TCK low phase starts T+1; rsp_valid_o at T+1+2·CLK_DIV·N; cmd_ready_o rises the cycle after rsp_valid_o. Back-to-back throughput: one command per 2·CLK_DIV·N+2 cycles.
- rsp_data_o holds value from DONE until next DONE or reset.
- cmd_len_i width is exact; no out-of-range lengths possible.

## Test plan
- Reset then TAP_RESET, CLK_DIV=2 → 6 TCK pulses, TMS 1,1,1,1,1,0, trst_no low for op, rsp_valid at T+25, rsp_data 0.
- SHIFT_DR len=7, data 0xA5, TDO looped to TDI through a model TAP bypass-free DR → 13 TCKs, TMS 1,0,0,0×7,1,1,0, TDI LSB-first 1,0,1,0,0,1,0,1, rsp at T+53, rsp_data = 0xA5.
- SHIFT_IR len=4 against SoC TAP (IDCODE IR) then SHIFT_DR len=31 → rsp_data = 0x04F5484D.
- SHIFT_DR len=31 (32 bits) with TDO tied 1 → rsp_data 0xFFFFFFFF; len=0 with TDO 1 → rsp_data 0x00000001, N=6.
- Reserved op 11 → no TCK edges, rsp_valid at T+1, rsp_data 0; cmd_valid held high in DONE not accepted until IDLE.
- rst_i asserted mid SHIFT (bit 3 of 8) → next cycle tck 0, tms 1, trst_no 0, busy 0, no rsp_valid; subsequent TAP_RESET completes normally.
